keccak_absorb: RTL and testbench
================================

# keccak_absorb

Sponge absorb front end for the Keccak-f[1600] datapath. It accepts a message as a stream of 64-bit little-endian lanes over a valid/ready handshake and XORs each lane into the rate portion of a 1600-bit state. It applies SHA-3/SHAKE multi-rate padding and launches one full permutation per rate block through a start/done interface. It sits directly upstream of keccak_statepermute, drives its load path, and takes the permuted state back between blocks.

## Interface
- RATE_LANES, 21, rate in 64-bit lanes (21 = SHAKE128/1344 bit, 17 = SHA3-256/SHAKE256); legal range 1..24
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; clears the state and begins a new message; honoured only in IDLE or DONE
- msg_i  in  64  message lane; byte k = bits [8k+7:8k]
- msg_vld  in  1  msg_i valid
- msg_last  in  1  final word of the message
- msg_bytes  in  4  valid bytes in the final word, 0..8; ignored when msg_last=0 (word treated as 8 bytes)
- msg_rdy  out  1  block accepts a word
- perm_start  out  1  one-cycle pulse; state_o is valid (load into permutation, init mode)
- state_o  out  1600  current state; lane i = state_o[64i+:64]
- perm_done  in  1  one-cycle pulse; perm_state_i holds the permuted state
- perm_state_i  in  1600  permutation result
- absorb_done  out  1  high in DONE: final padded block absorbed and permuted; state_o = squeeze-ready state

## Operation
- FSM states: IDLE, ABSORB, PAD, PERM, DONE. Reset enters IDLE.
- IDLE/DONE + start: state cleared to 0, lane_cnt=0, go to ABSORB.
- ABSORB, msg_rdy=1. On handshake, lane[lane_cnt] ^= masked msg_i. On the last word, bytes at index >= msg_bytes are zeroed before the XOR.
  - Non-last word with lane_cnt=RATE_LANES-1: lane_cnt wraps to 0, go to PERM with ret=ABSORB.
  - Last word: record pad position p = (lane_cnt, msg_bytes).
    - If msg_bytes=8, p advances to the next lane.
    - If that advance crosses the rate end, go to PERM with ret=PAD and p=(0,0).
    - Otherwise go to PAD.
- PAD, single cycle: XOR the domain byte at byte p.byte of lane p.lane, and XOR 0x80 into byte 7 of lane RATE_LANES-1. Both XOR (0x86 / 0x9F when they coincide). Then go to PERM with ret=DONE.
- PERM: perm_start pulses on the entry cycle only, then the block waits. On perm_done, state <= perm_state_i and the FSM goes to ret.
- DONE: absorb_done=1 until start.
- perm_done outside PERM is ignored. start outside IDLE/DONE is ignored. msg_vld outside ABSORB is not handshaken.

## Timing
- Reset values: msg_rdy=0, perm_start=0, absorb_done=0, state_o=0, lane_cnt=0.
- All outputs are registered; no combinational path from msg_vld to msg_rdy.
- One word is accepted per cycle in ABSORB.
- Block-filling handshake at cycle t: perm_start=1 at t+1, msg_rdy=0 from t+1.
- perm_done at cycle u: the state update is visible on state_o at u+1. msg_rdy=1 at u+1 when returning to ABSORB.
- Last word at t: PAD at t+1, perm_start at t+2.
- Empty message (msg_last, msg_bytes=0, lane_cnt=0) still pads and permutes exactly one block.
- Async rst at any point aborts the message; outputs return to reset values immediately.

## Configuration
- KECCAK_SHAKE_PAD_EN defined: domain byte 0x1F (SHAKE XOF).
- KECCAK_SHAKE_PAD_EN undefined: domain byte 0x06 (SHA3 hash).
- No other behavioural difference.

## Structure
- keccak_pkg holds:
  - KECCAK_W=1600 and LANE_W=64
  - SHA3/SHAKE domain-byte constants
  - the FSM state enum
  - the lane-index type
- One combinational sub-module, keccak_lane_pad, takes a lane, a byte count and a pad flag. It returns the byte-masked lane with the domain byte and/or the 0x80 terminator inserted. It is instantiated for the data lane and for the terminator lane.

## Test plan
- Empty message, RATE_LANES=21, macro undefined: start, then msg_last with msg_bytes=0. Required state_o at perm_start: lane0=0x06, lane20=0x8000000000000000, all else 0. Exactly one perm_start, then absorb_done=1.
- Same with KECCAK_SHAKE_PAD_EN: lane0=0x1F.
- 3-byte message 0x636261 ("abc") with the permutation stub echoing its input: lane0=0x06636261 after PAD, then absorb_done.
- 21 full words, last flagged with msg_bytes=8: perm_start after word 21. After perm_done, PAD writes lane0=0x06 and lane20 bit 63, a second perm_start follows, total two permutations.
- RATE_LANES=17, single word 0x0807060504030201 with msg_bytes=8: lane1=0x06 and lane16=0x8000000000000000. Separately, rst asserted mid-ABSORB gives msg_rdy=0 and state_o=0 on the same edge.
- Back-pressure: msg_vld held high through PERM is not accepted. msg_rdy stays 0 until the cycle after perm_done; no word is lost or duplicated (check the lane XOR pattern).

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants, FSM state encoding and lane index type for the Keccak sponge absorb front end.
package keccak_pkg;
    localparam int KECCAK_W  = 1600;
    localparam int LANE_W    = 64;
    localparam int NUM_LANES = KECCAK_W / LANE_W;

    localparam logic [7:0] SHA3_DOMAIN  = 8'h06;
    localparam logic [7:0] SHAKE_DOMAIN = 8'h1F;
    localparam logic [7:0] PAD_TERM     = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PAD,
        ST_PERM,
        ST_DONE
    } state_e;

    typedef logic [4:0] lane_idx_t;
endpackage

// File: rtl/keccak_lane_pad.sv
// Byte-masks one 64-bit lane to byte_cnt bytes and optionally inserts the domain byte
// just past the kept bytes and/or the 0x80 terminator in the top byte.
import keccak_pkg::*;

module keccak_lane_pad (
    input  logic [LANE_W-1:0] lane_i,
    input  logic [3:0]        byte_cnt,
    input  logic              dom_en,
    input  logic              term_en,
    input  logic [7:0]        domain,
    output logic [LANE_W-1:0] lane_o
);
    always_comb begin
        lane_o = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(byte_cnt)) begin
                lane_o[8*k +: 8] = lane_i[8*k +: 8];
            end else if (dom_en && (k == int'(byte_cnt))) begin
                lane_o[8*k +: 8] = domain;
            end
        end
        if (term_en) begin
            lane_o[LANE_W-1 -: 8] = lane_o[LANE_W-1 -: 8] ^ PAD_TERM;
        end
    end
endmodule

// File: rtl/keccak_absorb.sv
// Sponge absorb front end: XORs message lanes into the rate, pads, and launches one permutation per block.
// Define KECCAK_SHAKE_PAD_EN for the SHAKE domain byte (0x1F); otherwise the SHA3 domain byte (0x06) is used.
import keccak_pkg::*;

module keccak_absorb #(
    parameter int RATE_LANES = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LANE_W-1:0]   msg_i,
    input  logic                msg_vld,
    input  logic                msg_last,
    input  logic [3:0]          msg_bytes,
    output logic                msg_rdy,
    output logic                perm_start,
    output logic [KECCAK_W-1:0] state_o,
    input  logic                perm_done,
    input  logic [KECCAK_W-1:0] perm_state_i,
    output logic                absorb_done
);
`ifdef KECCAK_SHAKE_PAD_EN
    localparam logic [7:0] DOMAIN = SHAKE_DOMAIN;
`else
    localparam logic [7:0] DOMAIN = SHA3_DOMAIN;
`endif
    localparam lane_idx_t LAST_LANE = lane_idx_t'(RATE_LANES - 1);

    state_e state_q, state_d;
    state_e ret_q, ret_d;
    logic [NUM_LANES-1:0][LANE_W-1:0] st_q, st_d;
    lane_idx_t lane_cnt_q, lane_cnt_d;
    lane_idx_t pad_lane_q, pad_lane_d;
    logic [2:0] pad_byte_q, pad_byte_d;
    logic perm_start_q, perm_start_d;

    logic              last_full;
    logic              in_pad;
    logic [LANE_W-1:0] data_in;
    logic [3:0]        data_cnt;
    logic [LANE_W-1:0] data_pad;
    logic [LANE_W-1:0] term_pad;

    assign last_full = (msg_bytes >= 4'd8);
    assign in_pad    = (state_q == ST_PAD);

    // The data instance masks the incoming word in ABSORB and produces the domain byte in PAD.
    assign data_in  = in_pad ? '0 : msg_i;
    assign data_cnt = in_pad ? {1'b0, pad_byte_q}
                             : ((msg_last && !last_full) ? msg_bytes : 4'd8);

    keccak_lane_pad u_data_pad (
        .lane_i   (data_in),
        .byte_cnt (data_cnt),
        .dom_en   (in_pad),
        .term_en  (1'b0),
        .domain   (DOMAIN),
        .lane_o   (data_pad)
    );

    keccak_lane_pad u_term_pad (
        .lane_i   ('0),
        .byte_cnt (4'd0),
        .dom_en   (1'b0),
        .term_en  (1'b1),
        .domain   (DOMAIN),
        .lane_o   (term_pad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            st_q         <= '0;
            lane_cnt_q   <= '0;
            pad_lane_q   <= '0;
            pad_byte_q   <= '0;
            perm_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            st_q         <= st_d;
            lane_cnt_q   <= lane_cnt_d;
            pad_lane_q   <= pad_lane_d;
            pad_byte_q   <= pad_byte_d;
            perm_start_q <= perm_start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_ABSORB;
            end
            ST_ABSORB: begin
                if (msg_vld) begin
                    if (msg_last) begin
                        state_d = (last_full && (lane_cnt_q == LAST_LANE)) ? ST_PERM : ST_PAD;
                    end else if (lane_cnt_q == LAST_LANE) begin
                        state_d = ST_PERM;
                    end
                end
            end
            ST_PAD:  state_d = ST_PERM;
            ST_PERM: begin
                if (perm_done) state_d = ret_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        st_d       = st_q;
        lane_cnt_d = lane_cnt_q;
        ret_d      = ret_q;
        pad_lane_d = pad_lane_q;
        pad_byte_d = pad_byte_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    st_d       = '0;
                    lane_cnt_d = '0;
                end
            end
            ST_ABSORB: begin
                if (msg_vld) begin
                    st_d[lane_cnt_q] = st_q[lane_cnt_q] ^ data_pad;
                    if (msg_last) begin
                        lane_cnt_d = '0;
                        if (!last_full) begin
                            pad_lane_d = lane_cnt_q;
                            pad_byte_d = msg_bytes[2:0];
                        end else if (lane_cnt_q == LAST_LANE) begin
                            // A full final word that closes the block pads an entirely fresh block.
                            pad_lane_d = '0;
                            pad_byte_d = '0;
                            ret_d      = ST_PAD;
                        end else begin
                            pad_lane_d = lane_cnt_q + lane_idx_t'(1);
                            pad_byte_d = '0;
                        end
                    end else if (lane_cnt_q == LAST_LANE) begin
                        lane_cnt_d = '0;
                        ret_d      = ST_ABSORB;
                    end else begin
                        lane_cnt_d = lane_cnt_q + lane_idx_t'(1);
                    end
                end
            end
            ST_PAD: begin
                st_d[pad_lane_q] = st_d[pad_lane_q] ^ data_pad;
                st_d[LAST_LANE]  = st_d[LAST_LANE] ^ term_pad;
                ret_d            = ST_DONE;
            end
            ST_PERM: begin
                if (perm_done) st_d = perm_state_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        perm_start_d = (state_d == ST_PERM) && (state_q != ST_PERM);
        msg_rdy      = (state_q == ST_ABSORB);
        absorb_done  = (state_q == ST_DONE);
        perm_start   = perm_start_q;
        state_o      = st_q;
    end
endmodule

// File: tb/tb_keccak_absorb.sv
// Randomized self-checking bench for keccak_absorb against a byte-level sponge padding model.
// Define KECCAK_SHAKE_PAD_EN consistently for the RTL and this bench.
module tb_keccak_absorb;
    localparam int R  = 21;
    localparam int RB = R * 8;
`ifdef KECCAK_SHAKE_PAD_EN
    localparam logic [7:0] DOM = 8'h1F;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif

    typedef byte unsigned bq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   msg_i;
    logic          msg_vld;
    logic          msg_last;
    logic [3:0]    msg_bytes;
    logic          msg_rdy;
    logic          perm_start;
    logic [1599:0] state_o;
    logic          perm_done;
    logic [1599:0] perm_state_i;
    logic          absorb_done;

    int checks   = 0;
    int failures = 0;
    int perm_seen = 0;

    logic [1599:0] exp_before[$];
    bit            exp_rdy[$];
    logic [1599:0] exp_final;

    keccak_absorb #(.RATE_LANES(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .msg_i        (msg_i),
        .msg_vld      (msg_vld),
        .msg_last     (msg_last),
        .msg_bytes    (msg_bytes),
        .msg_rdy      (msg_rdy),
        .perm_start   (perm_start),
        .state_o      (state_o),
        .perm_done    (perm_done),
        .perm_state_i (perm_state_i),
        .absorb_done  (absorb_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (perm_start) perm_seen <= perm_seen + 1;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        int li;
        checks++;
        if (obs !== exp) begin
            failures++;
            li = 0;
            for (int i = 24; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) li = i;
            $display("[TB] FAIL %s lane%0d got=%h want=%h", tag, li, obs[64*li +: 64], exp[64*li +: 64]);
        end
    endtask

    function automatic logic [1599:0] fakePerm(input logic [1599:0] s);
        logic [1599:0] r;
        r = {s[1592:0], s[1599:1593]};
        for (int i = 0; i < 25; i++) r[64*i +: 64] = r[64*i +: 64] ^ (64'h9E3779B97F4A7C15 + 64'(i));
        return r;
    endfunction

    function automatic logic [1599:0] randState();
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Reference sponge: append domain byte, zero-fill, set 0x80 in last rate byte, absorb block by block.
    task automatic buildModel(input bq_t msg, input bit extra);
        byte unsigned p[$];
        logic [1599:0] s;
        int nb;
        p = msg;
        p.push_back(DOM);
        while ((p.size() % RB) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        nb = p.size() / RB;
        exp_before.delete();
        exp_rdy.delete();
        s = '0;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < RB; j++) s[8*j +: 8] = s[8*j +: 8] ^ p[b*RB + j];
            exp_before.push_back(s);
            exp_rdy.push_back((b < nb-1) && !((b == nb-2) && (msg.size() % RB == 0) && !extra));
            s = fakePerm(s);
        end
        exp_final = s;
    endtask

    task automatic sendMessage(input bq_t msg, input bit extra);
        int len, nw, lastBytes, cnt, idx;
        bit last;
        logic [63:0] word;
        len = msg.size();
        if (extra) begin nw = len/8 + 1; lastBytes = 0; end
        else if (len == 0) begin nw = 1; lastBytes = 0; end
        else begin nw = (len + 7) / 8; lastBytes = (len % 8 == 0) ? 8 : len % 8; end
        for (int w = 0; w < nw; w++) begin
            last = (w == nw-1);
            if ($urandom_range(0, 3) == 0) begin msg_vld = 1'b0; @(negedge clk); end
            for (int k = 0; k < 8; k++) begin
                idx = 8*w + k;
                word[8*k +: 8] = (idx < len) ? msg[idx] : 8'($urandom());
            end
            msg_i     = word;
            msg_last  = last;
            msg_bytes = last ? 4'(lastBytes) : 4'($urandom_range(0, 15));
            msg_vld   = 1'b1;
            start     = (w == 1);
            cnt = 0;
            while (!msg_rdy && cnt < 5000) begin @(negedge clk); cnt++; end
            if (cnt >= 5000) begin
                checkOutput("rdy_timeout", 0, 1);
                msg_vld = 1'b0; start = 1'b0;
                return;
            end
            @(negedge clk);
            start = 1'b0;
            if (last) begin
                checkOutput("rdy_after_last", msg_rdy, 0);
                checkOutput("perm_start_after_last", perm_start, (lastBytes == 8) && (w % R == R-1));
            end
        end
        msg_vld  = 1'b0;
        msg_last = 1'b0;
    endtask

    task automatic runPermStub(input int nb);
        int cnt;
        for (int k = 0; k < nb; k++) begin
            cnt = 0;
            while (!perm_start && cnt < 5000) begin @(negedge clk); cnt++; end
            if (cnt >= 5000) begin
                checkOutput("perm_start_timeout", 0, 1);
                return;
            end
            checkOutput("state_at_perm_start", state_o, exp_before[k]);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checkOutput("rdy_in_perm", msg_rdy, 0);
            end
            perm_state_i = fakePerm(state_o);
            perm_done    = 1'b1;
            @(negedge clk);
            perm_done    = 1'b0;
            perm_state_i = randState();
            checkOutput("state_after_perm", state_o, fakePerm(exp_before[k]));
            checkOutput("rdy_after_perm", msg_rdy, exp_rdy[k]);
        end
    endtask

    task automatic applyStimulus(input bq_t msg, input bit extra);
        int base, nb, cnt;
        buildModel(msg, extra);
        nb   = exp_before.size();
        base = perm_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rdy_after_start", msg_rdy, 1);
        checkOutput("state_cleared", state_o, '0);
        fork
            sendMessage(msg, extra);
            runPermStub(nb);
        join
        cnt = 0;
        while (!absorb_done && cnt < 100) begin @(negedge clk); cnt++; end
        checkOutput("absorb_done", absorb_done, 1);
        checkOutput("final_state", state_o, exp_final);
        repeat (3) @(negedge clk);
        checkOutput("perm_count", perm_seen - base, nb);
        perm_state_i = randState();
        perm_done = 1'b1;
        msg_vld   = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
        msg_vld   = 1'b0;
        checkOutput("done_ignores_perm_done", state_o, exp_final);
        checkOutput("done_holds", absorb_done, 1);
    endtask

    initial begin
        bq_t m;
        int len;
        bit extra;
        rst = 1'b1; start = 1'b0; msg_vld = 1'b0; msg_last = 1'b0;
        msg_i = '0; msg_bytes = '0; perm_done = 1'b0; perm_state_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rdy", msg_rdy, 0);
        checkOutput("reset_perm_start", perm_start, 0);
        checkOutput("reset_absorb_done", absorb_done, 0);
        checkOutput("reset_state", state_o, '0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_rdy", msg_rdy, 0);

        m.delete();
        applyStimulus(m, 1'b0);
        m = '{8'h61, 8'h62, 8'h63};
        applyStimulus(m, 1'b0);
        m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        applyStimulus(m, 1'b0);
        m.delete();
        for (int i = 0; i < RB; i++) m.push_back(8'($urandom()));
        applyStimulus(m, 1'b0);
        applyStimulus(m, 1'b1);
        m.delete();
        for (int i = 0; i < RB-1; i++) m.push_back(8'($urandom()));
        applyStimulus(m, 1'b0);

        repeat (10) begin
            len = $urandom_range(0, 400);
            m.delete();
            for (int i = 0; i < len; i++) m.push_back(8'($urandom()));
            extra = (len > 0 && len % 8 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(m, extra);
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        msg_vld = 1'b1; msg_last = 1'b0; msg_i = 64'h0123456789ABCDEF; msg_bytes = 4'd8;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_rdy", msg_rdy, 0);
        checkOutput("async_rst_state", state_o, '0);
        checkOutput("async_rst_perm_start", perm_start, 0);
        checkOutput("async_rst_done", absorb_done, 0);
        @(negedge clk);
        rst = 1'b0;
        msg_vld = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_rst", msg_rdy, 0);
        m = '{8'h61, 8'h62, 8'h63};
        applyStimulus(m, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
